// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types, sizing helpers and address slicing for the line sequencer
package mem_seq_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, DONE, DROP} state_t;
  localparam int LINE_BITS = 128;
  function automatic int beats_of(input int w);
    return LINE_BITS / w;
  endfunction
  function automatic int mem_shift_of(input int w);
    return $clog2(w / 8);
  endfunction
  function automatic int beat_idx_w_of(input int w);
    return $clog2(LINE_BITS / w);
  endfunction
  localparam int BEATS      = beats_of(32);
  localparam int MEM_SHIFT  = mem_shift_of(32);
  localparam int BEAT_IDX_W = beat_idx_w_of(32);
  // beat address = line address with the beat index appended below it
  function automatic logic [63:0] beat_addr(input logic [63:0] line_addr, input logic [63:0] beat, input int idx_w);
    return (line_addr << idx_w) | beat;
  endfunction
endpackage

// File: rtl/mem_line_sequencer.sv
// mem_line_sequencer: splits 128-bit cache line transfers into memory beats and reassembles reads
module mem_line_sequencer
  import mem_seq_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4,
  parameter int MEM_DATA_WIDTH       = 32
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic [BUS_ADDRESS_WIDTH-5:0]                           bus_addr_i,
  input  logic [LINE_BITS-1:0]                                   bus_data_i,
  input  logic                                                   bus_we_i,
  input  logic                                                   bus_valid_i,
  output logic [LINE_BITS-1:0]                                   bus_data_o,
  output logic                                                   bus_valid_o,
  output logic                                                   busy_o,
  output logic [BUS_ADDRESS_WIDTH-mem_shift_of(MEM_DATA_WIDTH)-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0]                              mem_data_o,
  output logic                                                   mem_we_o,
  output logic                                                   mem_req_o,
  input  logic [MEM_DATA_WIDTH-1:0]                              mem_data_i,
  input  logic                                                   mem_ack_i
);
  localparam int NBEATS = beats_of(MEM_DATA_WIDTH);
  localparam int IDX_W  = beat_idx_w_of(MEM_DATA_WIDTH);
  localparam int MAW    = BUS_ADDRESS_WIDTH - mem_shift_of(MEM_DATA_WIDTH);
  localparam int LAW    = BUS_ADDRESS_WIDTH - 4;
  if (BUS_DATA_WIDTH_SHIFT != 4) begin : g_bad_shift
    $error("mem_line_sequencer: only BUS_DATA_WIDTH_SHIFT=4 is supported");
  end
  if (MEM_DATA_WIDTH != 32 && MEM_DATA_WIDTH != 64) begin : g_bad_width
    $error("mem_line_sequencer: MEM_DATA_WIDTH must be 32 or 64");
  end
  state_t               state;
  logic [IDX_W-1:0]     beat;
  logic [LAW-1:0]       line_addr;
  logic                 we_q;
  logic [LINE_BITS-1:0] line_q;
  assign bus_data_o  = line_q;
  assign bus_valid_o = state == DONE;
  assign busy_o      = state != IDLE;
  assign mem_req_o   = state == BEAT;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = MAW'(beat_addr(64'(line_addr), 64'(beat), IDX_W));
  assign mem_data_o  = line_q[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beat      <= '0;
      line_addr <= '0;
      we_q      <= 1'b0;
      line_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus_valid_i) begin
          line_addr <= bus_addr_i;
          we_q      <= bus_we_i;
          beat      <= '0;
          if (bus_we_i) line_q <= bus_data_i;
          state     <= BEAT;
        end
        BEAT: if (mem_ack_i) begin
          if (!we_q) line_q[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_data_i;
          if (beat == IDX_W'(NBEATS - 1)) state <= DONE;
          else beat <= beat + IDX_W'(1);
        end
        DONE: state <= DROP;
        DROP: if (!bus_valid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
